im_loader_ctrl: RTL and testbench
=================================

Name: im_loader_ctrl

Overview:
- Sequences programming of the 16-word instruction memory.
- Accepts a valid/ready word stream, then issues one memWrite per word at consecutive word addresses.
- Arbitrates the IM address port between the loader and the CPU fetch PC.
- Holds the CPU stalled until a load completes cleanly.

Parameters:
- DEPTH, 16, number of IM words; a load ends at index DEPTH-1.
- AW, 4, word-index width; must satisfy 2^AW >= DEPTH.
- BOOT_RUN, 1, reset exit behaviour: 1 = enter RUN (execute the IM's reset-init contents); 0 = enter IDLE and wait for load_start.

Ports:
- clk  input  1  system clock; controller logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- load_start  input  1  single-cycle request to begin a new load.
- s_valid  input  1  stream word valid.
- s_data  input  32  stream instruction word.
- s_last  input  1  marks the final word of the load.
- s_ready  output  1  controller accepts the stream word this cycle.
- cpu_pc  input  32  CPU fetch byte address.
- im_addr  output  32  address to IM pc input.
- im_dataIn  output  32  write data to IM.
- im_memWrite  output  1  IM write enable.
- im_memRead  output  1  IM read enable.
- cpu_run  output  1  1 = CPU may fetch and execute; 0 = CPU stalled.
- load_done  output  1  one-cycle pulse on clean completion.
- load_err  output  1  sticky overflow or checksum error.
- word_count  output  AW+1  words written in the current or last load.

Behaviour:
- States: IDLE, LOAD, WRITE, RUN, ERROR.
- Reset values (async, reset=0):
  - state = RUN if BOOT_RUN, else IDLE.
  - Word pointer ptr = 0; word_count = 0.
  - im_memWrite = 0; im_dataIn = 0; load_done = 0; load_err = 0.
  - cpu_run = BOOT_RUN.
- Address mux (combinational):
  - im_addr = cpu_pc when state is RUN.
  - Otherwise im_addr = {(30-AW) zeros, ptr, 2'b00}.
- im_memRead = 1 in RUN, 0 otherwise.
- s_ready = 1 only in LOAD. It is combinational from state only, with no dependency on s_valid.
- IDLE, RUN or ERROR with load_start=1:
  - Go to LOAD; ptr = 0; word_count = 0.
  - load_err cleared; cpu_run = 0 on the next edge.
- LOAD, with s_valid && s_ready at posedge:
  - Register im_dataIn = s_data and latch s_last.
  - im_memWrite = 1; go to WRITE.
  - With no valid word, stay in LOAD.
- WRITE lasts exactly one cycle:
  - im_memWrite, im_addr and im_dataIn are held stable for the whole cycle, so the IM's negedge capture writes the word at word index ptr.
  - At the next posedge: im_memWrite = 0; word_count increments.
- WRITE exit:
  - Latched last=1: go to RUN, cpu_run = 1, load_done pulses for 1 cycle, ptr = 0.
  - Last=0 and ptr < DEPTH-1: ptr increments; return to LOAD.
  - Last=0 and ptr == DEPTH-1 (overflow): go to ERROR; load_err = 1; cpu_run stays 0.
- Throughput is 1 word per 2 cycles. Latency from accept to IM write is the negedge within the following cycle.
- Boundary conditions:
  - load_start during LOAD or WRITE is ignored.
  - s_last on the first word gives a 1-word load.
  - s_last exactly at index DEPTH-1 completes cleanly.
  - Reset mid-load aborts the load immediately. Partially written IM words are left as written; the IM's own reset reinitializes them.
  - ERROR exits only via load_start or reset.

Optional Feature:
- Macro: IM_LOAD_CKSUM_EN.
- When defined:
  - The controller keeps a running XOR of all accepted data words, cleared on load_start.
  - After the s_last word is written, go to a CKSUM state with s_ready=1. The next accepted beat is a checksum word and is not written to IM.
  - Match: proceed to RUN with load_done.
  - Mismatch: go to ERROR with load_err = 1.
- When undefined: there is no CKSUM state, no XOR register, and RUN follows the last WRITE directly.

Test Plan:
- Reset with BOOT_RUN=1, release -> cpu_run=1, im_addr tracks cpu_pc=0x8, im_memWrite=0, s_ready=0.
- load_start, then 3 words 0x1111, 0x2222, 0x3333 (last on the third) -> writes at addresses 0x0/0x4/0x8, word_count=3, load_done pulse, cpu_run=1.
- s_valid toggled 1-0-1 with idle gaps -> no writes in gap cycles; s_ready low during each WRITE; data order preserved.
- 16 words without s_last -> 16 writes, ERROR state, load_err=1, cpu_run=0; a new load_start clears load_err.
- Reset asserted during WRITE of word 5 -> all outputs at reset values immediately, im_memWrite=0 asynchronously.
- With IM_LOAD_CKSUM_EN: words 0xA, 0x5 then checksum 0xF -> RUN; checksum 0xE instead -> ERROR, load_err=1.

Source files
------------

// File: rtl/im_loader_ctrl.sv
// im_loader_ctrl: loads the 16-word instruction memory from a valid/ready word
// stream, then hands the IM address port back to the CPU fetch path.
//
// Optional feature: define IM_LOAD_CKSUM_EN to require a trailing XOR checksum
// beat after the s_last word before the CPU is released.
//
// Ports:
//   clk, reset           clock, async active-low reset
//   load_start           one-cycle request to start a new load
//   s_valid/s_data/s_last/s_ready   instruction word stream
//   cpu_pc               CPU fetch byte address
//   im_addr/im_dataIn/im_memWrite/im_memRead   IM port
//   cpu_run              CPU may fetch (0 = stalled)
//   load_done            one-cycle pulse on clean completion
//   load_err             sticky overflow / checksum error
//   word_count           words written in the current or last load
module im_loader_ctrl #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter bit          BOOT_RUN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    input  logic          s_last,
    output logic          s_ready,
    input  logic [31:0]   cpu_pc,
    output logic [31:0]   im_addr,
    output logic [31:0]   im_dataIn,
    output logic          im_memWrite,
    output logic          im_memRead,
    output logic          cpu_run,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   word_count
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
`ifdef IM_LOAD_CKSUM_EN
        ,
        ST_CKSUM = 3'd5
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW:0]     wcnt_q, wcnt_d;
    logic [31:0]     data_q, data_d;
    logic            wr_q, wr_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            run_q, run_d;
`ifdef IM_LOAD_CKSUM_EN
    logic [31:0]     cksum_q, cksum_d;
`endif

    // Combinational IM port steering and stream handshake (state only)
    always_comb begin
        im_memRead = (state_q == ST_RUN);
        im_addr    = (state_q == ST_RUN) ? cpu_pc : 32'({ptr_q, 2'b00});
        s_ready    = (state_q == ST_LOAD);
`ifdef IM_LOAD_CKSUM_EN
        if (state_q == ST_CKSUM) s_ready = 1'b1;
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        last_d  = last_q;
        done_d  = 1'b0;
        err_d   = err_q;
        run_d   = run_q;
`ifdef IM_LOAD_CKSUM_EN
        cksum_d = cksum_q;
`endif
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                    run_d   = 1'b0;
`ifdef IM_LOAD_CKSUM_EN
                    cksum_d = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    state_d = ST_WRITE;
                    data_d  = s_data;
                    last_d  = s_last;
                    wr_d    = 1'b1;
`ifdef IM_LOAD_CKSUM_EN
                    cksum_d = cksum_q ^ s_data;
`endif
                end
            end
            ST_WRITE: begin
                // The IM captures the held word on the negedge inside this cycle
                wcnt_d = wcnt_q + (AW+1)'(1);
                if (last_q) begin
`ifdef IM_LOAD_CKSUM_EN
                    state_d = ST_CKSUM;
`else
                    state_d = ST_RUN;
                    run_d   = 1'b1;
                    done_d  = 1'b1;
                    ptr_d   = '0;
`endif
                end else if (ptr_q < LAST_IDX) begin
                    state_d = ST_LOAD;
                    ptr_d   = ptr_q + AW'(1);
                end else begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end
            end
`ifdef IM_LOAD_CKSUM_EN
            ST_CKSUM: begin
                // Checksum beat is compared only, never written to the IM
                if (s_valid) begin
                    if (s_data == cksum_q) begin
                        state_d = ST_RUN;
                        run_d   = 1'b1;
                        done_d  = 1'b1;
                        ptr_d   = '0;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if (BOOT_RUN) state_q <= ST_RUN;
            else          state_q <= ST_IDLE;
            ptr_q   <= '0;
            wcnt_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= BOOT_RUN;
`ifdef IM_LOAD_CKSUM_EN
            cksum_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wcnt_q  <= wcnt_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            run_q   <= run_d;
`ifdef IM_LOAD_CKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    assign im_dataIn   = data_q;
    assign im_memWrite = wr_q;
    assign cpu_run     = run_q;
    assign load_done   = done_q;
    assign load_err    = err_q;
    assign word_count  = wcnt_q;

endmodule

// File: tb/tb_im_loader_ctrl.sv
// Bench for im_loader_ctrl: a write scoreboard (word i of a load lands at byte
// address 4*i) checked on every negedge, plus per-load end-state checks.
module tb_im_loader_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic [31:0] cpu_pc;
    logic [31:0] im_addr;
    logic [31:0] im_dataIn;
    logic        im_memWrite;
    logic        im_memRead;
    logic        cpu_run;
    logic        load_done;
    logic        load_err;
    logic [4:0]  word_count;

    im_loader_ctrl dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .cpu_pc(cpu_pc), .im_addr(im_addr), .im_dataIn(im_dataIn),
        .im_memWrite(im_memWrite), .im_memRead(im_memRead), .cpu_run(cpu_run),
        .load_done(load_done), .load_err(load_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int model_idx = 0;
    int done_cnt  = 0;
    int obs_n     = 0;
    bit mon_en    = 1'b0;
    logic [63:0] exp_q[$];
    logic [31:0] obs_addr [64];
    logic [31:0] obs_data [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard/invariant monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (im_memWrite) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", im_addr, im_dataIn);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", im_addr, e[63:32]);
                    chk("wr_data", im_dataIn, e[31:0]);
                end
                if (obs_n < 64) begin
                    obs_addr[obs_n] = im_addr;
                    obs_data[obs_n] = im_dataIn;
                end
                obs_n++;
            end
            chk("read_en_vs_run", 32'(im_memRead), 32'(cpu_run));
            if (cpu_run) chk("run_addr", im_addr, cpu_pc);
            chk("ready_and_write", 32'(s_ready & im_memWrite), 32'd0);
            if (load_done) done_cnt++;
        end
    end

    task automatic do_start();
        @(posedge clk); #1 load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
        model_idx = 0;
        done_cnt  = 0;
        obs_n     = 0;
    endtask

    // Present one beat and hold it until accepted; wr=0 for a non-IM beat
    task automatic send(input logic [31:0] d, input logic l, input bit wr);
        bit ok;
        ok = 1'b0;
        if (wr) begin
            exp_q.push_back({32'(model_idx * 4), d});
            model_idx++;
        end
        s_valid = 1'b1; s_data = d; s_last = l;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        else if (wr) chk("ready_low_in_write", 32'(s_ready), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_complete();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (cpu_run || load_err) ok = 1'b1;
        end
        if (!ok) chk("complete_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; load_start = 1'b0; s_valid = 1'b0;
        s_data = '0; s_last = 1'b0; cpu_pc = 32'h8;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_cpu_run", 32'(cpu_run), 32'd1);
        chk("rst_im_addr", im_addr, 32'h8);
        chk("rst_memwrite", 32'(im_memWrite), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        mon_en = 1'b1;

        // Basic 3-word load
        do_start();
        send(32'h1111, 1'b0, 1'b1);
        send(32'h2222, 1'b0, 1'b1);
        send(32'h3333, 1'b1, 1'b1);
        wait_complete();
        chk("l3_word_count", 32'(word_count), 32'd3);
        chk("l3_done_pulses", 32'(done_cnt), 32'd1);
        chk("l3_cpu_run", 32'(cpu_run), 32'd1);
        chk("l3_wr0_addr", obs_addr[0], 32'h0);
        chk("l3_wr1_addr", obs_addr[1], 32'h4);
        chk("l3_wr2_addr", obs_addr[2], 32'h8);
        chk("l3_wr2_data", obs_data[2], 32'h3333);
        chk("l3_pending", 32'(exp_q.size()), 32'd0);

        // Gapped stream with a load_start during LOAD that must be ignored
        cpu_pc = 32'h100;
        do_start();
        send(32'hA0, 1'b0, 1'b1);
        idle(3);
        chk("gap_ready", 32'(s_ready), 32'd1);
        load_start = 1'b1;
        idle(1);
        load_start = 1'b0;
        idle(2);
        send(32'hA1, 1'b0, 1'b1);
        idle(1);
        send(32'hA2, 1'b1, 1'b1);
        wait_complete();
        chk("gap_word_count", 32'(word_count), 32'd3);
        chk("gap_writes", 32'(obs_n), 32'd3);
        chk("gap_done_pulses", 32'(done_cnt), 32'd1);

        // One-word load
        do_start();
        send(32'h55, 1'b1, 1'b1);
        wait_complete();
        chk("one_word_count", 32'(word_count), 32'd1);
        chk("one_done_pulses", 32'(done_cnt), 32'd1);

        // Full 16-word load, s_last on the final index
        do_start();
        for (int i = 0; i < 16; i++) send(32'h100 + 32'(i), (i == 15), 1'b1);
        wait_complete();
        chk("full_word_count", 32'(word_count), 32'd16);
        chk("full_err", 32'(load_err), 32'd0);
        chk("full_cpu_run", 32'(cpu_run), 32'd1);
        chk("full_last_addr", obs_addr[15], 32'h3C);

        // Overflow: 16 words without s_last
        do_start();
        for (int i = 0; i < 16; i++) send(32'h200 + 32'(i), 1'b0, 1'b1);
        wait_complete();
        chk("ovf_err", 32'(load_err), 32'd1);
        chk("ovf_cpu_run", 32'(cpu_run), 32'd0);
        chk("ovf_word_count", 32'(word_count), 32'd16);
        chk("ovf_done_pulses", 32'(done_cnt), 32'd0);
        chk("ovf_s_ready", 32'(s_ready), 32'd0);
        chk("ovf_writes", 32'(obs_n), 32'd16);
        idle(3);
        chk("err_sticky", 32'(load_err), 32'd1);
        do_start();
        chk("restart_err_clear", 32'(load_err), 32'd0);
        chk("restart_ready", 32'(s_ready), 32'd1);

        // Reset during the WRITE of word 5
        for (int i = 0; i < 6; i++) send(32'h300 + 32'(i), 1'b0, 1'b1);
        chk("pre_rst_memwrite", 32'(im_memWrite), 32'd1);
        mon_en = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("arst_memwrite", 32'(im_memWrite), 32'd0);
        chk("arst_cpu_run", 32'(cpu_run), 32'd1);
        chk("arst_err", 32'(load_err), 32'd0);
        chk("arst_done", 32'(load_done), 32'd0);
        chk("arst_word_count", 32'(word_count), 32'd0);
        chk("arst_data", im_dataIn, 32'd0);
        chk("arst_s_ready", 32'(s_ready), 32'd0);
        exp_q.delete();
        idle(2);
        reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        chk("post_rst_addr", im_addr, cpu_pc);

`ifdef IM_LOAD_CKSUM_EN
        do_start();
        send(32'hA, 1'b0, 1'b1);
        send(32'h5, 1'b1, 1'b1);
        idle(2);
        chk("ck_wait_ready", 32'(s_ready), 32'd1);
        send(32'hF, 1'b0, 1'b0);
        wait_complete();
        chk("ck_ok_run", 32'(cpu_run), 32'd1);
        chk("ck_ok_done", 32'(done_cnt), 32'd1);
        chk("ck_ok_writes", 32'(obs_n), 32'd2);
        do_start();
        send(32'hA, 1'b0, 1'b1);
        send(32'h5, 1'b1, 1'b1);
        send(32'hE, 1'b0, 1'b0);
        wait_complete();
        chk("ck_bad_err", 32'(load_err), 32'd1);
        chk("ck_bad_run", 32'(cpu_run), 32'd0);
        chk("ck_bad_done", 32'(done_cnt), 32'd0);
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
